// File: rtl/ahb_periph_bridge.sv
// AHB-Lite slave front end for a single-cycle rd_en/wr_en peripheral register port.
// Adds write-error checking, read wait states with a bounded timeout, and two-cycle ERROR responses.
module ahb_periph_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  rd_en,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  ready,
    input  logic                  error
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WRITE, WCHK, READ, RDONE, ERR1, ERR2} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  accept, illegal, take, capture;
    logic                  unused_htrans;

    assign unused_htrans = HTRANS[0];
    assign accept  = HSEL & HREADY & HTRANS[1];
    assign illegal = (HADDR[1:0] != 2'b00) || (HSIZE != 3'b010);
    // Only a state that is completing (HREADYOUT=1) may start the next transfer.
    assign take    = HREADYOUT & accept;

    assign address = addr_q;
    assign wr_data = wr_en ? HWDATA : '0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: state_nxt = IDLE;
            WRITE: begin
                wr_en     = 1'b1;
                HREADYOUT = 1'b0;
                state_nxt = WCHK;
            end
            WCHK: begin
                if (error) begin
                    HREADYOUT = 1'b0;
                    state_nxt = ERR1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            READ: begin
                rd_en     = 1'b1;
                HREADYOUT = 1'b0;
                if (ready) begin
                    capture   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = RDONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt_nxt == CW'(TIMEOUT))
                        state_nxt = ERR1;
                end
            end
            RDONE: state_nxt = IDLE;
            ERR1: begin
                HRESP     = 1'b1;
                HREADYOUT = 1'b0;
                state_nxt = ERR2;
            end
            ERR2: begin
                HRESP     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (take) begin
            if (illegal) begin
                state_nxt = ERR1;
            end else if (HWRITE) begin
                state_nxt = WRITE;
            end else begin
                state_nxt = READ;
                cnt_nxt   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            HRDATA <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (take)
                addr_q <= HADDR;
            if (capture)
                HRDATA <= rd_data;
        end
    end

endmodule

// File: tb/tb_ahb_periph_bridge.sv
// Directed bench for ahb_periph_bridge: per-cycle vector table plus timeout and reset sequences.
module tb_ahb_periph_bridge;

    localparam logic       H  = 1'b1;
    localparam logic       L  = 1'b0;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] ID = 2'b00;
    localparam logic [2:0] WD = 3'b010;
    localparam logic [31:0] Z = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        HSEL, HWRITE, ready, error;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HADDR, HWDATA, rd_data;
    wire         HREADYOUT, HRESP, rd_en, wr_en;
    wire  [31:0] HRDATA, address, wr_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ahb_periph_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADYOUT), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .HRDATA(HRDATA), .rd_en(rd_en), .wr_en(wr_en), .address(address), .wr_data(wr_data),
        .rd_data(rd_data), .ready(ready), .error(error)
    );

    typedef struct packed {
        logic [95:0] tag;
        logic        sel;
        logic [1:0]  tr;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic        rdy;
        logic [31:0] rd;
        logic        err;
        logic        hro;
        logic        resp;
        logic        erd;
        logic        ewr;
        logic [31:0] eaddr;
        logic [31:0] ewd;
        logic [31:0] ehrd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(logic [95:0] tag, logic sel, logic [1:0] tr, logic wr, logic [2:0] sz,
                               logic [31:0] a, logic [31:0] wd, logic rdy, logic [31:0] rd, logic err,
                               logic hro, logic resp, logic erd, logic ewr,
                               logic [31:0] eaddr, logic [31:0] ewd, logic [31:0] ehrd);
        vec_t r;
        r = '{tag, sel, tr, wr, sz, a, wd, rdy, rd, err, hro, resp, erd, ewr, eaddr, ewd, ehrd};
        return r;
    endfunction

    task automatic check(input logic [95:0] tag, input logic [63:0] sig,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", tag, sig, act, exp);
        end
    endtask

    task automatic bus(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input logic rdy,
                       input logic [31:0] rd, input logic err);
        HSEL = sel; HTRANS = tr; HWRITE = wr; HSIZE = sz; HADDR = a; HWDATA = wd;
        ready = rdy; rd_data = rd; error = err;
    endtask

    task automatic check_all(input vec_t e);
        check(e.tag, "hreadyo", {31'b0, HREADYOUT}, {31'b0, e.hro});
        check(e.tag, "hresp",   {31'b0, HRESP},     {31'b0, e.resp});
        check(e.tag, "rd_en",   {31'b0, rd_en},     {31'b0, e.erd});
        check(e.tag, "wr_en",   {31'b0, wr_en},     {31'b0, e.ewr});
        check(e.tag, "address", address,            e.eaddr);
        check(e.tag, "wr_data", wr_data,            e.ewd);
        check(e.tag, "hrdata",  HRDATA,             e.ehrd);
    endtask

    initial begin
        int  rd_cnt;
        bit  done;

        // tag, sel, trans, write, size, haddr, hwdata, ready, rd_data, error | hro, resp, rd, wr, address, wr_data, hrdata
        vq.push_back(v("wr_a",    H, NS, H, WD, 32'h4000_0004, Z, L, Z, L,       H, L, L, L, Z, Z, Z));
        vq.push_back(v("wr_dp",   L, ID, L, WD, Z, 32'h64, L, Z, L,              L, L, L, H, 32'h4000_0004, 32'h64, Z));
        vq.push_back(v("wr_chk",  L, ID, L, WD, Z, Z, L, Z, L,                   H, L, L, L, 32'h4000_0004, Z, Z));
        vq.push_back(v("wr_idle", L, ID, L, WD, Z, Z, L, Z, L,                   H, L, L, L, 32'h4000_0004, Z, Z));
        vq.push_back(v("ue_a",    H, NS, H, WD, 32'h4000_0020, Z, L, Z, L,       H, L, L, L, 32'h4000_0004, Z, Z));
        vq.push_back(v("ue_dp",   L, ID, L, WD, Z, 32'hAB, L, Z, L,              L, L, L, H, 32'h4000_0020, 32'hAB, Z));
        vq.push_back(v("ue_chk",  L, ID, L, WD, Z, Z, L, Z, H,                   L, L, L, L, 32'h4000_0020, Z, Z));
        vq.push_back(v("ue_err1", L, ID, L, WD, Z, Z, L, Z, L,                   L, H, L, L, 32'h4000_0020, Z, Z));
        vq.push_back(v("ue_err2", L, ID, L, WD, Z, Z, L, Z, L,                   H, H, L, L, 32'h4000_0020, Z, Z));
        vq.push_back(v("ue_idle", L, ID, L, WD, Z, Z, L, Z, L,                   H, L, L, L, 32'h4000_0020, Z, Z));
        vq.push_back(v("rd_a",    H, NS, L, WD, 32'h4000_0014, Z, L, Z, L,       H, L, L, L, 32'h4000_0020, Z, Z));
        vq.push_back(v("rd_w0",   L, ID, L, WD, Z, Z, L, 32'h5, L,               L, L, H, L, 32'h4000_0014, Z, Z));
        vq.push_back(v("rd_w1",   L, ID, L, WD, Z, Z, L, 32'h6, L,               L, L, H, L, 32'h4000_0014, Z, Z));
        vq.push_back(v("rd_w2",   L, ID, L, WD, Z, Z, L, 32'h7, L,               L, L, H, L, 32'h4000_0014, Z, Z));
        vq.push_back(v("rd_rdy",  L, ID, L, WD, Z, Z, H, 32'h1, L,               L, L, H, L, 32'h4000_0014, Z, Z));
        vq.push_back(v("rd_done", L, ID, L, WD, Z, Z, L, Z, L,                   H, L, L, L, 32'h4000_0014, Z, 32'h1));
        vq.push_back(v("rd_idle", L, ID, L, WD, Z, Z, L, Z, L,                   H, L, L, L, 32'h4000_0014, Z, 32'h1));
        vq.push_back(v("mis_a",   H, NS, L, WD, 32'h4000_0006, Z, H, 32'h9, L,   H, L, L, L, 32'h4000_0014, Z, 32'h1));
        vq.push_back(v("mis_e1",  L, ID, L, WD, Z, Z, H, 32'h9, L,               L, H, L, L, 32'h4000_0006, Z, 32'h1));
        vq.push_back(v("mis_e2",  L, ID, L, WD, Z, Z, H, 32'h9, L,               H, H, L, L, 32'h4000_0006, Z, 32'h1));
        vq.push_back(v("mis_idle",L, ID, L, WD, Z, Z, L, Z, L,                   H, L, L, L, 32'h4000_0006, Z, 32'h1));
        vq.push_back(v("sz_a",    H, NS, H, 3'b000, 32'h4000_0008, Z, L, Z, L,   H, L, L, L, 32'h4000_0006, Z, 32'h1));
        vq.push_back(v("sz_e1",   L, ID, L, WD, Z, 32'h99, L, Z, L,              L, H, L, L, 32'h4000_0008, Z, 32'h1));
        vq.push_back(v("sz_e2",   L, ID, L, WD, Z, Z, L, Z, L,                   H, H, L, L, 32'h4000_0008, Z, 32'h1));
        vq.push_back(v("p_wr_a",  H, NS, H, WD, 32'h4000_0010, Z, L, Z, L,       H, L, L, L, 32'h4000_0008, Z, 32'h1));
        vq.push_back(v("p_wr_dp", L, ID, L, WD, Z, 32'h55, L, Z, L,              L, L, L, H, 32'h4000_0010, 32'h55, 32'h1));
        vq.push_back(v("p_chk_rd",H, NS, L, WD, 32'h4000_000C, 32'hFFFF, L, Z, L, H, L, L, L, 32'h4000_0010, Z, 32'h1));
        vq.push_back(v("p_rd",    L, ID, L, WD, Z, Z, H, 32'h1234, L,            L, L, H, L, 32'h4000_000C, Z, 32'h1));
        vq.push_back(v("p_done_wr",H, NS, H, WD, 32'h4000_0018, Z, L, Z, L,      H, L, L, L, 32'h4000_000C, Z, 32'h1234));
        vq.push_back(v("p_wr2_dp",L, ID, L, WD, Z, 32'h77, L, Z, L,              L, L, L, H, 32'h4000_0018, 32'h77, 32'h1234));
        vq.push_back(v("p_chk_err",L, ID, L, WD, Z, Z, L, Z, H,                  L, L, L, L, 32'h4000_0018, Z, 32'h1234));
        vq.push_back(v("p_err1",  L, ID, L, WD, Z, Z, L, Z, L,                   L, H, L, L, 32'h4000_0018, Z, 32'h1234));
        vq.push_back(v("p_err2_rd",H, NS, L, WD, 32'h4000_0000, Z, L, Z, L,      H, H, L, L, 32'h4000_0018, Z, 32'h1234));
        vq.push_back(v("p_rd2",   L, ID, L, WD, Z, Z, H, 32'hCAFE, L,            L, L, H, L, 32'h4000_0000, Z, 32'h1234));
        vq.push_back(v("p_done2", L, ID, L, WD, Z, Z, L, Z, L,                   H, L, L, L, 32'h4000_0000, Z, 32'hCAFE));
        vq.push_back(v("ww_a",    H, NS, H, WD, 32'h4000_001C, Z, L, Z, L,       H, L, L, L, 32'h4000_0000, Z, 32'hCAFE));
        vq.push_back(v("ww_dp1",  L, ID, L, WD, Z, 32'h11, L, Z, L,              L, L, L, H, 32'h4000_001C, 32'h11, 32'hCAFE));
        vq.push_back(v("ww_chk_wr",H, NS, H, WD, 32'h4000_0024, Z, L, Z, L,      H, L, L, L, 32'h4000_001C, Z, 32'hCAFE));
        vq.push_back(v("ww_dp2",  L, ID, L, WD, Z, 32'h22, L, Z, L,              L, L, L, H, 32'h4000_0024, 32'h22, 32'hCAFE));
        vq.push_back(v("ww_chk",  L, ID, L, WD, Z, Z, L, Z, L,                   H, L, L, L, 32'h4000_0024, Z, 32'hCAFE));
        vq.push_back(v("nosel",   L, NS, H, WD, 32'h4000_0030, Z, L, Z, L,       H, L, L, L, 32'h4000_0024, Z, 32'hCAFE));
        vq.push_back(v("busy",    H, 2'b01, L, WD, 32'h4000_0034, Z, L, Z, L,    H, L, L, L, 32'h4000_0024, Z, 32'hCAFE));
        vq.push_back(v("after",   L, ID, L, WD, Z, Z, H, Z, L,                   H, L, L, L, 32'h4000_0024, Z, 32'hCAFE));

        rst = 1'b1;
        bus(L, ID, L, WD, Z, Z, L, Z, L);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all(v("reset", L, ID, L, WD, Z, Z, L, Z, L, H, L, L, L, Z, Z, Z));

        foreach (vq[i]) begin
            @(negedge clk);
            bus(vq[i].sel, vq[i].tr, vq[i].wr, vq[i].sz, vq[i].a, vq[i].wd, vq[i].rdy, vq[i].rd, vq[i].err);
            #1;
            check_all(vq[i]);
        end

        // Read that never sees ready: expect exactly TIMEOUT strobe cycles, then ERR1/ERR2.
        @(negedge clk);
        bus(H, NS, L, WD, 32'h4000_0028, Z, L, Z, L);
        #1;
        check("to_a", "hreadyo", {31'b0, HREADYOUT}, 32'h1);
        rd_cnt = 0;
        done   = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            bus(L, ID, L, WD, Z, Z, L, 32'hDEAD, L);
            #1;
            if (HRESP) begin
                done = 1'b1;
            end else begin
                if (rd_en) rd_cnt++;
                check("to_wait", "hreadyo", {31'b0, HREADYOUT}, 32'h0);
            end
        end
        check("to_bound", "done", {31'b0, done}, 32'h1);
        check("to_rd_cyc", "count", rd_cnt, 32'd16);
        check_all(v("to_err1", L, ID, L, WD, Z, Z, L, Z, L, L, H, L, L, 32'h4000_0028, Z, 32'hCAFE));
        @(negedge clk);
        #1;
        check_all(v("to_err2", L, ID, L, WD, Z, Z, L, Z, L, H, H, L, L, 32'h4000_0028, Z, 32'hCAFE));
        @(negedge clk);
        #1;
        check_all(v("to_idle", L, ID, L, WD, Z, Z, L, Z, L, H, L, L, L, 32'h4000_0028, Z, 32'hCAFE));

        // Reset while the peripheral read is outstanding.
        @(negedge clk);
        bus(H, NS, L, WD, 32'h4000_002C, Z, L, Z, L);
        @(negedge clk);
        bus(L, ID, L, WD, Z, Z, L, Z, L);
        #1;
        check("rst_rd", "rd_en", {31'b0, rd_en}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all(v("rst_mid", L, ID, L, WD, Z, Z, L, Z, L, H, L, L, L, Z, Z, Z));
        @(negedge clk);
        bus(L, ID, L, WD, Z, Z, H, 32'h3, L);
        #1;
        check_all(v("rst_after", L, ID, L, WD, Z, Z, H, 32'h3, L, H, L, L, L, Z, Z, Z));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
